// File: rtl/decoder_bcd_to_decimal_hold.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_bcd_to_decimal_hold
//  Description : Decodes an accepted BCD digit into a one-hot decimal line
//                and holds it for DWELL_CYCLES clock cycles. A ready/valid
//                handshake paces the input. Illegal codes (10..15) blank
//                the output and raise error_o.
//  Revision    : 1.0  initial release
//
//  Parameters
//    DWELL_CYCLES  cycles each digit stays on signal_o (1..256, default 4)
//
//  Ports
//    clk_i     in   1   clock, rising edge
//    rst_ni    in   1   synchronous active-low reset
//    bcd_i     in   4   BCD digit
//    valid_i   in   1   bcd_i valid this cycle
//    ready_o   out  1   digit can be accepted this cycle (combinational)
//    clear_i   in   1   synchronous abort back to idle
//    signal_o  out  10  one-hot decimal line
//    valid_o   out  1   signal_o carries a held digit
//    error_o   out  1   illegal BCD code seen
//
//  Configuration macro
//    DECODER_BCD_ERROR_STICKY_EN  defined   : error_o sticky until reset/clear
//                                 undefined : error_o one-cycle pulse
// ============================================================================
module decoder_bcd_to_decimal_hold #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] bcd_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       clear_i,
  output logic [9:0] signal_o,
  output logic       valid_o,
  output logic       error_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Counter is loaded with DWELL_CYCLES-1: the load edge itself provides
  // the first held cycle, so the countdown covers the remaining ones.
  localparam logic [7:0] c_DWELL_M1 = 8'(DWELL_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [9:0] r_signal;
  logic       r_error;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [9:0] w_signal_nxt;
  logic       w_error_nxt;
  logic       w_ready;
  logic       w_accept;
  logic       w_legal;

  // Ready in IDLE, or in the last HOLD cycle so a new digit can follow
  // without an idle bubble.
  assign w_ready  = ~clear_i & ((r_state == S_IDLE) | (r_cnt == 8'd0));
  assign w_accept = valid_i & w_ready;
  assign w_legal  = (bcd_i <= 4'd9);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_signal <= 10'd0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_signal <= w_signal_nxt;
      r_error  <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_signal_nxt = r_signal;
`ifdef DECODER_BCD_ERROR_STICKY_EN
    w_error_nxt  = r_error;
`else
    w_error_nxt  = 1'b0;
`endif

    if (clear_i) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = 8'd0;
      w_signal_nxt = 10'd0;
      w_error_nxt  = 1'b0;
    end else if (w_accept) begin
      if (w_legal) begin
        w_state_nxt  = S_HOLD;
        w_cnt_nxt    = c_DWELL_M1;
        w_signal_nxt = 10'd1 << bcd_i;
      end else begin
        w_state_nxt  = S_IDLE;
        w_cnt_nxt    = 8'd0;
        w_signal_nxt = 10'd0;
        w_error_nxt  = 1'b1;
      end
    end else if (r_state == S_HOLD) begin
      if (r_cnt != 8'd0) begin
        w_cnt_nxt = r_cnt - 8'd1;
      end else begin
        w_state_nxt  = S_IDLE;
        w_signal_nxt = 10'd0;
      end
    end
  end

  assign ready_o  = w_ready;
  assign signal_o = r_signal;
  assign valid_o  = |r_signal;
  assign error_o  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_decoder_bcd_to_decimal_hold.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_bcd_to_decimal_hold
//  Description : Bench for decoder_bcd_to_decimal_hold. Two instances
//                (DWELL_CYCLES=4 and 1) share the stimulus; each is compared
//                every cycle with a model that tracks the held digit and the
//                number of output cycles it still has left.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decoder_bcd_to_decimal_hold;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr;
  logic       vld;
  logic [3:0] bcd;

  logic       rdy4, vo4, er4;
  logic [9:0] sig4;
  logic       rdy1, vo1, er1;
  logic [9:0] sig1;

  decoder_bcd_to_decimal_hold #(.DWELL_CYCLES(4)) u_dut4 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bcd_i   (bcd),
    .valid_i (vld),
    .ready_o (rdy4),
    .clear_i (clr),
    .signal_o(sig4),
    .valid_o (vo4),
    .error_o (er4)
  );

  decoder_bcd_to_decimal_hold #(.DWELL_CYCLES(1)) u_dut1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bcd_i   (bcd),
    .valid_i (vld),
    .ready_o (rdy1),
    .clear_i (clr),
    .signal_o(sig1),
    .valid_o (vo1),
    .error_o (er1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model per instance: held digit (-1 = none), output cycles left, error.
  int dwell [2] = '{4, 1};
  int digit [2];
  int left  [2];
  bit err   [2];
  bit m_init = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A new digit may be taken when the current one is in its last cycle.
  function automatic bit m_ready(int k);
    return !clr && (left[k] <= 1);
  endfunction

  function automatic logic [31:0] m_sig(int k);
    logic [31:0] one;
    one = 32'd1;
    return (digit[k] < 0) ? 32'd0 : (one << digit[k]);
  endfunction

  task automatic model_step(int k, bit r, bit c, bit v, logic [3:0] b);
    bit acc;
    acc = v && m_ready(k);
    if (!r || c) begin
      digit[k] = -1; left[k] = 0; err[k] = 1'b0;
    end else begin
`ifndef DECODER_BCD_ERROR_STICKY_EN
      err[k] = 1'b0;
`endif
      if (acc) begin
        if (b <= 4'd9) begin
          digit[k] = int'(b); left[k] = dwell[k];
        end else begin
          digit[k] = -1; left[k] = 0; err[k] = 1'b1;
        end
      end else if (left[k] > 0) begin
        left[k]--;
        if (left[k] == 0) digit[k] = -1;
      end
    end
  endtask

  task automatic cycle(bit r, bit c, bit v, logic [3:0] b);
    rst_n = r; clr = c; vld = v; bcd = b;
    #1;
    if (m_init) begin
      check("ready4", 32'(rdy4), 32'(m_ready(0)));
      check("ready1", 32'(rdy1), 32'(m_ready(1)));
    end
    @(posedge clk);
    model_step(0, r, c, v, b);
    model_step(1, r, c, v, b);
    if (!r) m_init = 1'b1;
    #1;
    if (m_init) begin
      check("signal4", 32'(sig4), m_sig(0));
      check("valid4",  32'(vo4),  32'(digit[0] >= 0));
      check("error4",  32'(er4),  32'(err[0]));
      check("signal1", 32'(sig1), m_sig(1));
      check("valid1",  32'(vo1),  32'(digit[1] >= 0));
      check("error1",  32'(er1),  32'(err[1]));
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; vld = 1'b0; bcd = 4'd0;
    @(posedge clk); #1;

    // Reset
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b1, 1'b1, 4'd3);
    idle(1);

    // Single digit 7, held 4 cycles then released
    cycle(1'b1, 1'b0, 1'b1, 4'd7);
    check("req028_sig7", 32'(sig4), 32'h080);
    idle(6);

    // Back-to-back 3 then 9 with valid held high
    cycle(1'b1, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 4'd9);
    idle(5);

    // Illegal code, then clear
    cycle(1'b1, 1'b0, 1'b1, 4'd12);
    idle(2);
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    idle(1);

    // Clear beats a simultaneous valid
    cycle(1'b1, 1'b0, 1'b1, 4'd5);
    idle(1);
    cycle(1'b1, 1'b1, 1'b1, 4'd2);
    check("req031_cleared", 32'(sig4), 32'd0);
    idle(3);

    // Reset in the middle of a hold
    cycle(1'b1, 1'b0, 1'b1, 4'd0);
    idle(1);
    cycle(1'b0, 1'b0, 1'b1, 4'd4);
    check("req032_rst", 32'({sig4, vo4, er4}), 32'd0);
    idle(2);

    // Digit sweep every cycle (one digit per cycle on the dwell-1 unit)
    for (int d = 0; d < 10; d++) cycle(1'b1, 1'b0, 1'b1, 4'(d));
    idle(5);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bit r, c, v;
      logic [3:0] b;
      r = ($urandom % 40) != 0;
      c = ($urandom % 12) == 0;
      v = ($urandom % 4) != 0;
      b = (($urandom % 5) == 0) ? 4'(10 + ($urandom % 6)) : 4'($urandom % 10);
      cycle(r, c, v, b);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoder_bcd_to_decimal_hold.md
DECODER_BCD_TO_DECIMAL_HOLD -- requirements
Module: decoder_bcd_to_decimal_hold

Interface
REQ-001 Parameter DWELL_CYCLES, default 4, number of clock cycles each decoded digit is held on the output (legal range 1..256).
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 bcd_i  input  4  BCD digit to decode.
REQ-005 valid_i  input  1  bcd_i is valid this cycle.
REQ-006 ready_o  output  1  block can accept a digit this cycle.
REQ-007 clear_i  input  1  synchronous abort, clears output and returns to IDLE.
REQ-008 signal_o  output  10  one-hot decimal line, bit n high for digit n.
REQ-009 valid_o  output  1  signal_o carries a held digit.
REQ-010 error_o  output  1  an illegal BCD code (10..15) was presented.

Function
REQ-011 The FSM SHALL have two states: IDLE and HOLD, plus an 8-bit down-counter cnt.
REQ-012 ready_o SHALL be combinational: 1 in IDLE, 1 in HOLD when cnt==0, else 0; forced 0 while clear_i=1.
REQ-013 A digit SHALL be accepted at a rising edge where valid_i & ready_o & ~clear_i.
REQ-014 On accepting a legal code n (0..9), at that edge signal_o SHALL become 1<<n, valid_o 1, cnt DWELL_CYCLES-1, state HOLD (latency 1 edge).
REQ-015 signal_o/valid_o SHALL then stay constant for exactly DWELL_CYCLES cycles.
REQ-016 In HOLD with cnt>0, cnt SHALL decrement by 1 per cycle; valid_i SHALL be ignored (ready_o=0).
REQ-017 In HOLD with cnt==0 and no acceptance, the next edge SHALL clear signal_o to 0, valid_o to 0 and go to IDLE.
REQ-018 In HOLD with cnt==0 and an acceptance, the new digit SHALL load directly (back-to-back, no idle bubble).
REQ-019 On accepting an illegal code (10..15), signal_o and valid_o SHALL go to 0, state to IDLE, and error_o SHALL be asserted for the following cycle only (see REQ-026).
REQ-020 signal_o SHALL always be one-hot or all-zero; valid_o SHALL equal |signal_o.
REQ-021 clear_i=1 SHALL at the next edge zero signal_o, valid_o, cnt, go to IDLE; clear_i SHALL take priority over a simultaneous valid_i.
REQ-022 With DWELL_CYCLES=1, every HOLD cycle has cnt==0, so a continuous valid_i stream SHALL be accepted every cycle.

Reset
REQ-023 When rst_ni=0 at a rising edge: state IDLE, cnt 0, signal_o 0, valid_o 0, error_o 0; rst_ni SHALL override clear_i and valid_i.
REQ-024 Reset asserted mid-HOLD SHALL abort the held digit with no further output.
REQ-025 ready_o SHALL be 1 in the first cycle after reset release.

Configuration
REQ-026 Macro DECODER_BCD_ERROR_STICKY_EN: when defined, error_o SHALL be sticky, set on any illegal code and cleared only by reset or clear_i; when undefined, error_o SHALL be a one-cycle pulse per illegal code.
REQ-027 Decode, hold timing and handshake SHALL be identical with or without the macro.

Verification (DWELL_CYCLES=4 unless stated)
REQ-028 Reset then bcd_i=7, valid_i=1 one cycle -> signal_o=10'b0010000000, valid_o=1 for exactly 4 cycles, then 0, ready_o back to 1.
REQ-029 Continuous valid_i with bcd_i=3 then 9 -> signal_o=0x008 for 4 cycles immediately followed by 0x200 for 4 cycles, no gap.
REQ-030 bcd_i=12, valid_i=1 -> signal_o=0, valid_o=0, error_o=1 one cycle (macro undefined) or until clear_i (macro defined).
REQ-031 Accept bcd_i=5, assert clear_i with valid_i=1, bcd_i=2 two cycles later -> outputs 0 next edge, digit 2 not accepted.
REQ-032 Accept bcd_i=0, drive rst_ni=0 in second hold cycle -> all outputs 0 next edge, ready_o=1 after release.
REQ-033 DWELL_CYCLES=1, sweep bcd_i 0..9 every cycle -> signal_o steps 0x001..0x200 one per cycle, 1-edge latency.
